// File: rtl/dcache_mem_arbiter_pkg.sv
// Shared constants and types for the cache/memory-port arbiter.
package dcache_mem_arbiter_pkg;

  localparam int unsigned WORD        = 32;
  localparam int unsigned ADDR        = 32;
  localparam int unsigned LINE_WORDS  = 4;
  localparam int unsigned CNT_W       = $clog2(LINE_WORDS);
  localparam int unsigned OFFSET_BITS = CNT_W + 2;

  localparam logic [ADDR-1:0] OFFSET_MASK = ADDR'((1 << OFFSET_BITS) - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_ADDR = 3'd3,
    ST_WR_DATA = 3'd4,
    ST_WR_RESP = 3'd5
  } state_e;

  // Captured transaction: line address plus which cache owns a refill
  typedef struct packed {
    logic            sel_d;
    logic [ADDR-1:0] addr;
  } xfer_t;

  function automatic logic [ADDR-1:0] line_align(input logic [ADDR-1:0] a);
    return a & ~OFFSET_MASK;
  endfunction

endpackage

// File: rtl/dcache_mem_arbiter_rr_arbiter2.sv
// Two-input round-robin picker for the ICache (a) and DCache (b) read requesters.
module dcache_mem_arbiter_rr_arbiter2 (
  input  logic req_a,
  input  logic req_b,
  input  logic last_b,
  output logic gnt_a_c,
  output logic gnt_b_c
);

  // On a tie, b wins unless it was the most recent winner
  always_comb begin
    gnt_b_c = req_b & (~req_a | ~last_b);
    gnt_a_c = req_a & ~gnt_b_c;
  end

endmodule

// File: rtl/dcache_mem_arbiter.sv
// Shares the single memory port between ICache refills, DCache refills and
// DCache write-backs; one fixed-length burst at a time.
module dcache_mem_arbiter
  import dcache_mem_arbiter_pkg::*;
(
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       i_rd_req,
  input  logic [ADDR-1:0]            i_rd_addr,
  output logic                       i_rd_gnt,
  output logic                       i_ret_valid,
  input  logic                       d_rd_req,
  input  logic [ADDR-1:0]            d_rd_addr,
  output logic                       d_rd_gnt,
  output logic                       d_ret_valid,
  output logic [WORD-1:0]            ret_data,
  output logic                       ret_last,
  input  logic                       d_wr_req,
  input  logic [ADDR-1:0]            d_wr_addr,
  input  logic [WORD*LINE_WORDS-1:0] d_wr_data,
  output logic                       d_wr_gnt,
  output logic                       d_wr_done,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [ADDR-1:0]            mem_addr,
  input  logic                       mem_ack,
  output logic                       mem_wvalid,
  output logic [WORD-1:0]            mem_wdata,
  output logic                       mem_wlast,
  input  logic                       mem_wready,
  input  logic                       mem_rvalid,
  input  logic [WORD-1:0]            mem_rdata,
  input  logic                       mem_bvalid,
  output logic                       busy
);

  state_e                              state_q, state_d;
  logic [CNT_W-1:0]                    cnt_q;
  logic                                last_d_q;
  xfer_t                               xfer_q;
  logic [LINE_WORDS-1:0][WORD-1:0]     line_q;

  logic pick_i_c, pick_d_c;
  logic grant_wr_c, grant_rd_c;
  logic cnt_last_c, rd_beat_c, wr_beat_c;

  dcache_mem_arbiter_rr_arbiter2 u_rr (
    .req_a   (i_rd_req),
    .req_b   (d_rd_req),
    .last_b  (last_d_q),
    .gnt_a_c (pick_i_c),
    .gnt_b_c (pick_d_c)
  );

  // Write-back always beats refills so a victim leaves before its line is refetched
  assign grant_wr_c = (state_q == ST_IDLE) & d_wr_req;
  assign grant_rd_c = (state_q == ST_IDLE) & ~d_wr_req & (i_rd_req | d_rd_req);
  assign cnt_last_c = (cnt_q == CNT_W'(LINE_WORDS - 1));
  assign rd_beat_c  = (state_q == ST_RD_DATA) & mem_rvalid;
  assign wr_beat_c  = (state_q == ST_WR_DATA) & mem_wready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and memory-side / return-path outputs
  always_comb begin
    state_d     = state_q;
    busy        = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = xfer_q.addr;
    mem_wvalid  = 1'b0;
    mem_wdata   = '0;
    mem_wlast   = 1'b0;
    i_ret_valid = 1'b0;
    d_ret_valid = 1'b0;
    ret_last    = 1'b0;
    ret_data    = mem_rdata;
    case (state_q)
      ST_IDLE: begin
        if (grant_wr_c)      state_d = ST_WR_ADDR;
        else if (grant_rd_c) state_d = ST_RD_ADDR;
      end
      ST_RD_ADDR: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        if (mem_ack) state_d = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        busy        = 1'b1;
        i_ret_valid = mem_rvalid & ~xfer_q.sel_d;
        d_ret_valid = mem_rvalid & xfer_q.sel_d;
        ret_last    = mem_rvalid & cnt_last_c;
        if (mem_rvalid && cnt_last_c) state_d = ST_IDLE;
      end
      ST_WR_ADDR: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ack) state_d = ST_WR_DATA;
      end
      ST_WR_DATA: begin
        busy       = 1'b1;
        mem_we     = 1'b1;
        mem_wvalid = 1'b1;
        mem_wdata  = line_q[cnt_q];
        mem_wlast  = cnt_last_c;
        if (mem_wready && cnt_last_c) state_d = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        busy   = 1'b1;
        mem_we = 1'b1;
        if (mem_bvalid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Grant pulses, write-done pulse, capture registers and beat counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      i_rd_gnt  <= 1'b0;
      d_rd_gnt  <= 1'b0;
      d_wr_gnt  <= 1'b0;
      d_wr_done <= 1'b0;
      last_d_q  <= 1'b0;
      xfer_q    <= '0;
      line_q    <= '0;
      cnt_q     <= '0;
    end else begin
      i_rd_gnt  <= grant_rd_c & pick_i_c;
      d_rd_gnt  <= grant_rd_c & pick_d_c;
      d_wr_gnt  <= grant_wr_c;
      d_wr_done <= (state_q == ST_WR_RESP) & mem_bvalid;
      if (grant_wr_c) begin
        xfer_q.addr  <= line_align(d_wr_addr);
        xfer_q.sel_d <= 1'b1;
        line_q       <= d_wr_data;
      end else if (grant_rd_c) begin
        xfer_q.addr  <= pick_d_c ? line_align(d_rd_addr) : line_align(i_rd_addr);
        xfer_q.sel_d <= pick_d_c;
        last_d_q     <= pick_d_c;
      end
      if (state_q == ST_IDLE) begin
        cnt_q <= '0;
      end else if (rd_beat_c || wr_beat_c) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dcache_mem_arbiter.sv
// Randomized scoreboard bench: a transaction-level model predicts the ordered
// event stream, a memory responder drives the bus, a monitor compares.
module tb_dcache_mem_arbiter;
  import dcache_mem_arbiter_pkg::*;

  localparam int LW = int'(LINE_WORDS);

  localparam logic [2:0] K_GI = 3'd0, K_GD = 3'd1, K_GW = 3'd2, K_ADDR = 3'd3;
  localparam logic [2:0] K_RI = 3'd4, K_RD = 3'd5, K_WB = 3'd6, K_DONE = 3'd7;

  typedef struct packed {
    logic [2:0]  kind;
    logic [31:0] data;
    logic        last;
  } ev_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic i_rd_req = 1'b0, d_rd_req = 1'b0, d_wr_req = 1'b0;
  logic [31:0] i_rd_addr = '0, d_rd_addr = '0, d_wr_addr = '0;
  logic [LW*32-1:0] d_wr_data = '0;
  logic i_rd_gnt, i_ret_valid, d_rd_gnt, d_ret_valid, ret_last, d_wr_gnt, d_wr_done;
  logic [31:0] ret_data, mem_addr, mem_wdata;
  logic mem_req, mem_we, mem_wvalid, mem_wlast, busy;
  logic mem_ack = 1'b0, mem_wready = 1'b0, mem_rvalid = 1'b0, mem_bvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  ev_t         exp_q[$];
  logic [31:0] rd_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  bit          model_last_d = 1'b0;
  int          rd_left = 0;
  bit          resp_pend = 1'b0;

  always #5 clk = ~clk;

  dcache_mem_arbiter dut (
    .clk(clk), .rstn(rstn),
    .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr), .i_rd_gnt(i_rd_gnt), .i_ret_valid(i_ret_valid),
    .d_rd_req(d_rd_req), .d_rd_addr(d_rd_addr), .d_rd_gnt(d_rd_gnt), .d_ret_valid(d_ret_valid),
    .ret_data(ret_data), .ret_last(ret_last),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
    .d_wr_gnt(d_wr_gnt), .d_wr_done(d_wr_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_wvalid(mem_wvalid), .mem_wdata(mem_wdata), .mem_wlast(mem_wlast), .mem_wready(mem_wready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_bvalid(mem_bvalid), .busy(busy)
  );

  function automatic ev_t mk(input logic [2:0] kind, input logic [31:0] data, input logic last);
    ev_t e;
    e.kind = kind;
    e.data = data;
    e.last = last;
    return e;
  endfunction

  function automatic void check_ev(input string name, input ev_t got);
    ev_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s: got kind=%0d data=0x%08h last=%0d, required no event", name, got.kind, got.data, got.last);
    end else begin
      e = exp_q.pop_front();
      if (e != got) begin
        miscompares++;
        $display("FAIL %s: got kind=%0d data=0x%08h last=%0d, required kind=%0d data=0x%08h last=%0d",
                 name, got.kind, got.data, got.last, e.kind, e.data, e.last);
      end
    end
  endfunction

  function automatic void check_val(input string name, input logic [63:0] got, input logic [63:0] req);
    vectors++;
    if (got !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, req);
    end
  endfunction

  function automatic logic [31:0] aligned(input logic [31:0] a);
    return a - (a % 32'(LW * 4));
  endfunction

  // Reference model: one whole transaction as the ordered events it must produce
  function automatic void add_read(input bit is_d, input logic [31:0] a);
    logic [31:0] w;
    exp_q.push_back(mk(is_d ? K_GD : K_GI, 32'h0, 1'b0));
    exp_q.push_back(mk(K_ADDR, aligned(a), 1'b0));
    for (int k = 0; k < LW; k++) begin
      w = $urandom;
      rd_q.push_back(w);
      exp_q.push_back(mk(is_d ? K_RD : K_RI, w, k == LW - 1));
    end
    model_last_d = is_d;
  endfunction

  function automatic void add_write(input logic [31:0] a, input logic [LW*32-1:0] line);
    exp_q.push_back(mk(K_GW, 32'h0, 1'b0));
    exp_q.push_back(mk(K_ADDR, aligned(a), 1'b1));
    for (int k = 0; k < LW; k++) exp_q.push_back(mk(K_WB, line[k*32 +: 32], k == LW - 1));
    exp_q.push_back(mk(K_DONE, 32'h0, 1'b0));
  endfunction

  function automatic logic [LW*32-1:0] rand_line();
    logic [LW*32-1:0] l;
    for (int k = 0; k < LW; k++) l[k*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [11:0] ctl_outs();
    return {busy, i_rd_gnt, d_rd_gnt, d_wr_gnt, d_wr_done, i_ret_valid, d_ret_valid,
            ret_last, mem_req, mem_we, mem_wvalid, mem_wlast};
  endfunction

  // Memory responder: random ack delay, read gaps, wready and bvalid; spurious rvalid/bvalid when idle
  initial begin
    bit n_ack, n_rv, n_wr, n_bv;
    logic [31:0] n_rd;
    forever begin
      @(negedge clk);
      n_ack = 1'b0; n_rv = 1'b0; n_wr = 1'b0; n_bv = 1'b0; n_rd = '0;
      if (!rstn) begin
        rd_left = 0;
        resp_pend = 1'b0;
        rd_q.delete();
      end else begin
        if (rd_left > 0 && mem_rvalid) begin
          rd_left--;
          if (rd_q.size() > 0) rd_q.delete(0);
        end
        if (resp_pend && mem_bvalid) resp_pend = 1'b0;
        if (mem_wvalid && mem_wready && mem_wlast) resp_pend = 1'b1;
        if (mem_req && mem_ack && !mem_we) rd_left = LW;
        n_ack = mem_req && !mem_ack && ($urandom_range(2) == 0);
        n_rd = $urandom;
        if (rd_left > 0) begin
          n_rv = ($urandom_range(3) != 0);
          if (rd_q.size() > 0) n_rd = rd_q[0];
        end else begin
          n_rv = ($urandom_range(4) == 0);
        end
        n_wr = ($urandom_range(1) == 1);
        n_bv = resp_pend ? ($urandom_range(2) == 0) : ($urandom_range(5) == 0);
      end
      @(posedge clk);
      #1;
      mem_ack = n_ack; mem_rvalid = n_rv; mem_rdata = n_rd; mem_wready = n_wr; mem_bvalid = n_bv;
    end
  end

  // Monitor: every observable DUT event pops and compares one expectation
  initial begin
    forever begin
      @(negedge clk);
      if (!rstn) begin
        exp_q.delete();
      end else begin
        if (i_rd_gnt)              check_ev("i_rd_gnt", mk(K_GI, 32'h0, 1'b0));
        if (d_rd_gnt)              check_ev("d_rd_gnt", mk(K_GD, 32'h0, 1'b0));
        if (d_wr_gnt)              check_ev("d_wr_gnt", mk(K_GW, 32'h0, 1'b0));
        if (mem_req && mem_ack)    check_ev("mem_addr", mk(K_ADDR, mem_addr, mem_we));
        if (i_ret_valid)           check_ev("i_ret", mk(K_RI, ret_data, ret_last));
        if (d_ret_valid)           check_ev("d_ret", mk(K_RD, ret_data, ret_last));
        if (mem_wvalid && mem_wready) check_ev("mem_wbeat", mk(K_WB, mem_wdata, mem_wlast));
        if (d_wr_done)             check_ev("d_wr_done", mk(K_DONE, 32'h0, 1'b0));
      end
    end
  end

  // Raise a set of requests together, hold each until granted, wait for all to drain
  task automatic run_batch(input bit wr, input bit ri, input bit rd, input logic [31:0] wa,
                           input logic [31:0] ia, input logic [31:0] da, input logic [LW*32-1:0] line);
    bit pw, pi, pd, done;
    pw = wr; pi = ri; pd = rd; done = 1'b0;
    if (wr) add_write(wa, line);
    if (ri && rd) begin
      if (model_last_d) begin add_read(1'b0, ia); add_read(1'b1, da); end
      else begin add_read(1'b1, da); add_read(1'b0, ia); end
    end else if (ri) add_read(1'b0, ia);
    else if (rd) add_read(1'b1, da);
    d_wr_req = wr; d_wr_addr = wa; d_wr_data = line;
    i_rd_req = ri; i_rd_addr = ia; d_rd_req = rd; d_rd_addr = da;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (d_wr_gnt) pw = 1'b0;
      if (i_rd_gnt) pi = 1'b0;
      if (d_rd_gnt) pd = 1'b0;
      if (!pw && !pi && !pd && exp_q.size() == 0 && !busy) begin done = 1'b1; break; end
      @(posedge clk);
      #1;
      d_wr_req = pw; i_rd_req = pi; d_rd_req = pd;
      if (!pw) d_wr_data = rand_line();
    end
    if (!done) check_val("batch_timeout", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit found, wr, ri, rd;
    logic [LW*32-1:0] line_a;
    #3;
    check_val("reset_ctl_outs", 64'(ctl_outs()), 64'd0);
    check_val("reset_mem_addr", 64'(mem_addr), 64'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    run_batch(1'b0, 1'b1, 1'b1, 32'h0, 32'h2000_0104, 32'h3000_0208, rand_line());
    run_batch(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h1000_0014, rand_line());
    for (int k = 0; k < LW; k++) line_a[k*32 +: 32] = 32'hA0 + 32'(k);
    run_batch(1'b1, 1'b0, 1'b1, 32'h4000_0038, 32'h0, 32'h4000_0038, line_a);

    // Reset in the middle of the second refill beat
    add_read(1'b1, 32'h5000_0040);
    d_rd_req = 1'b1; d_rd_addr = 32'h5000_0040;
    found = 1'b0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (d_rd_gnt) d_rd_req = 1'b0;
      @(posedge clk);
      #2;
      if (mem_rvalid && rd_left == LW - 1) begin found = 1'b1; break; end
    end
    if (!found) check_val("second_beat_timeout", 64'd0, 64'd1);
    rstn = 1'b0;
    d_rd_req = 1'b0;
    #1;
    check_val("mid_burst_reset_outs", 64'(ctl_outs()), 64'd0);
    model_last_d = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    check_val("post_reset_busy", 64'(busy), 64'd0);
    run_batch(1'b0, 1'b1, 1'b1, 32'h0, 32'h6000_0010, 32'h7000_0020, rand_line());

    for (int b = 0; b < 40; b++) begin
      wr = ($urandom_range(2) == 0);
      ri = ($urandom_range(1) == 1);
      rd = ($urandom_range(1) == 1);
      if (!wr && !ri && !rd) rd = 1'b1;
      run_batch(wr, ri, rd, $urandom, $urandom, $urandom, rand_line());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
